// File: rtl/jt51_noise_monitor.sv
// JT51 noise-channel monitor: decodes attenuation/sign per operator-31 strobe and
// estimates NFRQ[4:1] from the shortest run of equal sign bits over a sample window.
module jt51_noise_monitor #(
    parameter int unsigned WINDOW = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cen,
    input  logic        i_op31_no,
    input  logic [10:0] i_noise,
    output logic [9:0]  o_eg_out,
    output logic        o_sign_out,
    output logic        o_eg_valid,
    output logic [4:0]  o_run_min,
    output logic [3:0]  o_nfrq_est,
    output logic        o_est_valid,
    output logic        o_est_err
);

    typedef enum logic [1:0] {StIdle, StSync, StMeasure} state_t;

    localparam logic [15:0] WinLast = 16'(WINDOW - 1);

    state_t      r_state, w_state_next;
    logic        r_prev_sign, w_prev_sign_next;
    logic [7:0]  r_run_len, w_run_len_next;
    logic [15:0] r_win_cnt, w_win_cnt_next;
    logic [7:0]  r_min_acc, w_min_acc_next;
    logic [9:0]  r_eg_out, w_eg_out_next;
    logic        r_sign_out, w_sign_out_next;
    logic        r_eg_valid, w_eg_valid_next;
    logic [4:0]  r_run_min, w_run_min_next;
    logic [3:0]  r_nfrq_est, w_nfrq_est_next;
    logic        r_est_valid, w_est_valid_next;
    logic        r_est_err, w_est_err_next;

    logic        w_qual;
    logic        w_sign;
    logic        w_run_end;
    logic        w_win_end;
    logic [7:0]  w_min_upd;
    logic [4:0]  w_nfrq_diff;

    assign w_qual      = i_cen & i_op31_no;
    assign w_sign      = i_noise[10];
    assign w_run_end   = (w_sign != r_prev_sign);
    assign w_win_end   = (r_win_cnt == WinLast);
    // Minimum including the run that ends on this very sample.
    assign w_min_upd   = (w_run_end && (r_run_len < r_min_acc)) ? r_run_len : r_min_acc;
    assign w_nfrq_diff = 5'd16 - w_min_upd[4:0];

    always_comb begin
        w_state_next     = r_state;
        w_prev_sign_next = r_prev_sign;
        w_run_len_next   = r_run_len;
        w_win_cnt_next   = r_win_cnt;
        w_min_acc_next   = r_min_acc;
        w_eg_out_next    = r_eg_out;
        w_sign_out_next  = r_sign_out;
        w_eg_valid_next  = r_eg_valid;
        w_run_min_next   = r_run_min;
        w_nfrq_est_next  = r_nfrq_est;
        w_est_valid_next = 1'b0;
        w_est_err_next   = 1'b0;

        if (w_qual) begin
            w_sign_out_next  = w_sign;
            w_eg_out_next    = w_sign ? i_noise[9:0] : ~i_noise[9:0];
            w_eg_valid_next  = 1'b1;
            w_prev_sign_next = w_sign;

            unique case (r_state)
                StIdle: begin
                    w_state_next = StSync;
                end
                StSync: begin
                    if (w_run_end) begin
                        w_run_len_next = 8'd1;
                        w_win_cnt_next = 16'd0;
                        w_min_acc_next = 8'd255;
                        w_state_next   = StMeasure;
                    end
                end
                StMeasure: begin
                    if (w_run_end) begin
                        w_run_len_next = 8'd1;
                    end else if (r_run_len != 8'd255) begin
                        w_run_len_next = r_run_len + 8'd1;
                    end

                    if (w_win_end) begin
                        w_win_cnt_next = 16'd0;
                        w_min_acc_next = 8'd255;
                        if ((w_min_upd >= 8'd1) && (w_min_upd <= 8'd16)) begin
                            w_nfrq_est_next  = w_nfrq_diff[3:0];
                            w_run_min_next   = w_min_upd[4:0];
                            w_est_valid_next = 1'b1;
                        end else begin
                            w_run_min_next = (w_min_upd > 8'd31) ? 5'd31 : w_min_upd[4:0];
                            w_est_err_next = 1'b1;
                        end
                    end else begin
                        w_win_cnt_next = r_win_cnt + 16'd1;
                        w_min_acc_next = w_min_upd;
                    end
                end
                default: begin
                    w_state_next = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_prev_sign <= 1'b0;
            r_run_len   <= 8'd0;
            r_win_cnt   <= 16'd0;
            r_min_acc   <= 8'd0;
            r_eg_out    <= 10'd0;
            r_sign_out  <= 1'b0;
            r_eg_valid  <= 1'b0;
            r_run_min   <= 5'd0;
            r_nfrq_est  <= 4'd0;
            r_est_valid <= 1'b0;
            r_est_err   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_prev_sign <= w_prev_sign_next;
            r_run_len   <= w_run_len_next;
            r_win_cnt   <= w_win_cnt_next;
            r_min_acc   <= w_min_acc_next;
            r_eg_out    <= w_eg_out_next;
            r_sign_out  <= w_sign_out_next;
            r_eg_valid  <= w_eg_valid_next;
            r_run_min   <= w_run_min_next;
            r_nfrq_est  <= w_nfrq_est_next;
            r_est_valid <= w_est_valid_next;
            r_est_err   <= w_est_err_next;
        end
    end

    assign o_eg_out    = r_eg_out;
    assign o_sign_out  = r_sign_out;
    assign o_eg_valid  = r_eg_valid;
    assign o_run_min   = r_run_min;
    assign o_nfrq_est  = r_nfrq_est;
    assign o_est_valid = r_est_valid;
    assign o_est_err   = r_est_err;

endmodule

// File: doc/jt51_noise_monitor.md
# jt51_noise_monitor

Receive-side checker for the JT51 noise channel. It samples the 11-bit noise word on every operator-31 strobe and decodes the envelope attenuation and the random sign bit from it. It also measures the shortest run of identical sign bits over a fixed sample window and converts that run into an estimate of the programmed noise frequency (NFRQ[4:1]). It sits beside the noise generator, in simulation benches and in the on-FPGA debug build, and feeds status registers.

## Interface
- `WINDOW`, 256: qualifying samples per measurement window; legal range 32..65535.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `cen` in 1: clock enable; the block holds all state when low.
- `op31_no` in 1: sample strobe. A sample qualifies only when `cen` and `op31_no` are both high.
- `noise` in 11: noise word, {sign, 10-bit magnitude field}.
- `eg_out` out 10: decoded attenuation.
- `sign_out` out 1: decoded sign bit, `noise[10]`.
- `eg_valid` out 1: high once the first sample has been captured since reset.
- `run_min` out 5: shortest complete run in the last window, saturated at 31.
- `nfrq_est` out 4: estimated NFRQ[4:1].
- `est_valid` out 1: one-`clk` pulse when a window completes with a good estimate.
- `est_err` out 1: one-`clk` pulse when a window completes with no usable run.

## Operation
- **Decode.** On each qualifying sample: `sign_out` <= `noise[10]`; `eg_out` <= `noise[10] ? noise[9:0] : ~noise[9:0]`; `eg_valid` <= 1.
- **Run counter.** `run_len` is 8 bits and saturates at 255.
  - If `noise[10]` equals the previous sign, `run_len` increments.
  - Otherwise the run has ended: its length is `run_len`, and `run_len` is reloaded to 1.
- **States.** IDLE, SYNC, MEASURE.
  - IDLE: the first qualifying sample stores the sign. Go to SYNC.
  - SYNC: wait for the first sign change. That run is partial and is discarded. On the change, set `run_len`=1, `win_cnt`=0 and `min_acc`=255, then go to MEASURE.
  - MEASURE: every qualifying sample increments `win_cnt`. Each completed run updates `min_acc` <= `min(min_acc, run_len)`.
    - The sample where `win_cnt` reaches `WINDOW`-1 ends the window. That sample's own run end, if any, is included in the minimum.
    - At window end, `min_acc` and `win_cnt` reset. `run_len` continues unchanged. The state stays MEASURE, so windows run back to back.
- **Window evaluation** uses `m` = final `min_acc`.
  - 1 <= `m` <= 16: `nfrq_est` <= 16-`m`, `run_min` <= `m`, pulse `est_valid`.
  - Otherwise (no run completed, or `m` > 16): `run_min` <= `min(m,31)`, `nfrq_est` holds its previous value, pulse `est_err`.
- **Arithmetic.** `16-m` is computed in 5 bits; only the low 4 bits are kept. `m`=16 gives 0 and `m`=1 gives 15.
- **Non-qualifying cycles.** If `op31_no` is low or `cen` is low, nothing changes. `est_valid` and `est_err` still drop on the next `clk`.

## Timing
- **Reset values:** `eg_out`=0, `sign_out`=0, `eg_valid`=0, `run_min`=0, `nfrq_est`=0, `est_valid`=0, `est_err`=0; state IDLE, all counters 0.
- **Latency:**
  - `eg_out`, `sign_out` and `eg_valid` update on the `clk` edge that samples the qualifying strobe (1-cycle latency).
  - `est_valid`/`est_err` assert on the edge that samples the window-ending sample and stay high exactly one `clk`. `run_min` and `nfrq_est` update on that same edge.
- **Reset priority:** reset asserted mid-window discards all partial results and returns to IDLE. Reset wins over a simultaneous qualifying sample.
- **Simultaneous events:** a run end and the window end on the same sample are both counted in the closing window. The new `run_len`=1 carries into the next window.
- **First estimate:** no estimate is produced before SYNC completes plus `WINDOW` qualifying samples.

## Test plan
- **Decode.** Drive `noise`=0x400|0x155 -> `eg_out`=0x155, `sign_out`=1. Drive 0x0AA -> `eg_out`=0x355, `sign_out`=0. Both appear one `clk` after the strobe.
- **Fixed-period pattern.** Sign alternates every 4 samples, `WINDOW`=256 -> `run_min`=4, `nfrq_est`=12, and `est_valid` pulses every 256 samples after sync.
- **Generator loopback.** Connect to `jt51_noise` with NFRQ=31, then with NFRQ=0, over 8 windows. NFRQ=31 -> `nfrq_est`=15 in every window. NFRQ=0 -> `nfrq_est`=0 in at least 7 of the 8 windows.
- **Stuck sign.** Hold the sign at 1 for 600 samples -> `est_err` pulses, `run_min`=31, `nfrq_est` unchanged, `est_valid` never asserted.
- **Strobe gating.** Keep `op31_no`=1 with `cen` toggling 1/0 -> only the `cen`=1 cycles count. The result matches the ungated run.
- **Reset mid-window.** Assert `rst` at sample 100 of a window -> all outputs return to 0 on the next edge. The next estimate arrives only after a fresh sync plus 256 samples.
